io_bus_arbiter: RTL and testbench
=================================

// Module: io_bus_arbiter
// PURPOSE
//  Shares the AS2650 internal peripheral bus (gpios/timers/serial_ports/sid) between the CPU
//  IO port and the Wishbone host. The CPU has priority and zero-latency pass-through. Wishbone
//  accesses are slotted into idle cycles. A starvation counter forces a one-cycle CPU hold so
//  the host is always served. Sits between as2650 ext_io_* and the per-device bus_* nets.
// PARAMETERS
//  MAX_WAIT  8  cycles a WB request may wait behind the CPU before a forced slot (1..255)
// PORTS
//  wb_clk_i     in   1  clock
//  rst_n        in   1  synchronous reset, active low
//  cpu_cyc      in   1  CPU IO cycle active
//  cpu_we       in   1  CPU write
//  cpu_addr     in   8  CPU IO address; [7:6] device, [5:0] register
//  cpu_dat_o    in   8  CPU write data
//  cpu_dat_i    out  8  read data to CPU
//  cpu_hold     out  1  CPU must stall and hold its request stable
//  wb_io_sel    in   1  wrapper decode: this WB access targets the IO bus
//  wbs_cyc_i, wbs_stb_i, wbs_we_i  in 1 each; wbs_adr_i in 9; wbs_dat_i in 8
//  wbs_dat_o    out  8  registered read data;  wbs_ack_o  out 1  one-cycle ack
//  bus_cyc out 1; bus_addr out 6; bus_data_out out 8; bus_we_{gpios,timers,serial_ports,sid} out 1 each
//  bus_in_{gpios,timers,serial_ports,sid}  in  8 each  device read data
// BEHAVIOUR
//  - wb_req = wbs_cyc_i & wbs_stb_i & wb_io_sel. Owner = WB only in state XFER, else CPU.
//  - Owner drives bus_cyc/bus_addr/bus_data_out combinationally; bus_we_<dev> = owner_cyc & owner_we
//    & (addr[7:6]==dev). Read mux on addr[7:6]: 0 gpios, 1 timers, 2 serial_ports, 3 sid.
//  - cpu_dat_i = mux output in the same cycle (no latency) when CPU owns the bus, else 8'h00.
//  - FSM states IDLE, WAIT, XFER, ACK; wait_cnt is 8 bits.
//    IDLE: wb_req & !cpu_cyc -> XFER; wb_req & cpu_cyc -> WAIT with wait_cnt=0.
//    WAIT: !wb_req -> IDLE, no ack (abort). !cpu_cyc -> XFER.
//          wait_cnt==MAX_WAIT-1 -> XFER (forced). Otherwise wait_cnt++.
//    XFER: WB owns the bus for exactly 1 cycle; cpu_hold=cpu_cyc; CPU strobes are suppressed.
//          Read: wbs_dat_o <= mux. Write: data from wbs_dat_i, one-cycle bus_we_<dev>. -> ACK.
//    ACK:  wbs_ack_o=1 for exactly 1 cycle -> IDLE. A request still asserted next cycle is new.
//  - Latency, idle bus: req sampled cycle N -> XFER N+1 -> wbs_ack_o high N+2.
//  - Worst-case WB latency is MAX_WAIT+2 cycles. cpu_hold is high in at most 1 of every
//    MAX_WAIT+2 cycles.
//  - cpu_hold is combinational. The CPU is never held outside XFER.
//  - A CPU request arriving in the same cycle as XFER waits; it is never dropped.
//  - Reset (rst_n=0 at a clock edge): state IDLE, wait_cnt 0, wbs_dat_o 8'h00, wbs_ack_o 0.
//    While rst_n=0 the CPU owns the bus; a reset in XFER/ACK drops the ack, with no further
//    WB strobe.
// CONFIGURATION
//  IO_ARB_STATS_EN defined:
//    - Adds 16-bit saturating counters: wb_grants (+1 per XFER) and forced_holds (+1 per
//      forced XFER). Both reset to 0.
//    - WB read with wbs_adr_i[8]=1 skips the bus and goes IDLE->ACK. Data is
//      wb_grants[7:0]/[15:8] and forced_holds[7:0]/[15:8] for wbs_adr_i[1:0]=0..3.
//    - WB write with wbs_adr_i[8]=1 clears both counters.
//  IO_ARB_STATS_EN undefined: no counters; wbs_adr_i[8] is ignored; all accesses go to the bus.
// TESTING
//  1 Idle CPU, WB write adr 0x41 dat 0x5A -> bus_we_timers high 1 cycle with addr 0x01 data 0x5A;
//    ack 2 cycles after req.
//  2 CPU reads adr 0xC3 with bus_in_sid=0x77 -> cpu_dat_i=0x77 same cycle; cpu_hold=0.
//  3 cpu_cyc held high, WB read adr 0x02 -> forced XFER after 8 cycles; cpu_hold high 1 cycle;
//    wbs_dat_o=bus_in_gpios; ack.
//  4 WB req in WAIT, drop stb before slot -> no ack, no bus_we_*; FSM returns to IDLE.
//  5 rst_n low during XFER of a write -> no ack, FSM IDLE, wbs_dat_o=0; CPU access works next cycle.
//  6 (IO_ARB_STATS_EN) after test 3, read adr 0x102 -> wbs_dat_o=0x01; write adr 0x100 -> counters 0.

Source files
------------

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares the peripheral IO bus between the CPU (priority, zero latency) and Wishbone.
// Optional IO_ARB_STATS_EN adds saturating grant/forced-hold counters readable at wbs_adr_i[8]=1.
module io_bus_arbiter #(
    parameter int MAX_WAIT = 8
) (
    input  logic       wb_clk_i,
    input  logic       rst_n,
    input  logic       cpu_cyc,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_dat_o,
    output logic [7:0] cpu_dat_i,
    output logic       cpu_hold,
    input  logic       wb_io_sel,
    input  logic       wbs_cyc_i,
    input  logic       wbs_stb_i,
    input  logic       wbs_we_i,
    input  logic [8:0] wbs_adr_i,
    input  logic [7:0] wbs_dat_i,
    output logic [7:0] wbs_dat_o,
    output logic       wbs_ack_o,
    output logic       bus_cyc,
    output logic [5:0] bus_addr,
    output logic [7:0] bus_data_out,
    output logic       bus_we_gpios,
    output logic       bus_we_timers,
    output logic       bus_we_serial_ports,
    output logic       bus_we_sid,
    input  logic [7:0] bus_in_gpios,
    input  logic [7:0] bus_in_timers,
    input  logic [7:0] bus_in_serial_ports,
    input  logic [7:0] bus_in_sid
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_ACK} state_t;
    state_t r_state, w_next;
    logic [7:0] r_wait_cnt, r_dat, w_mux, w_stat_dat;
    logic       w_wb_req, w_wb_own, w_own_cyc, w_own_we, w_wait_max, w_forced, w_stat, w_stat_rd;
    logic [1:0] w_dev;

    assign w_wb_req   = wbs_cyc_i & wbs_stb_i & wb_io_sel;
    assign w_wait_max = r_wait_cnt == 8'(MAX_WAIT - 1);
    assign w_forced   = (r_state == S_WAIT) & w_wb_req & cpu_cyc & w_wait_max;
    assign w_stat_rd  = (r_state == S_IDLE) & w_wb_req & w_stat & !wbs_we_i;

    always_ff @(posedge wb_clk_i)
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = !w_wb_req ? S_IDLE : w_stat ? S_ACK : cpu_cyc ? S_WAIT : S_XFER;
            S_WAIT:  w_next = !w_wb_req ? S_IDLE : (!cpu_cyc || w_wait_max) ? S_XFER : S_WAIT;
            S_XFER:  w_next = S_ACK;
            default: w_next = S_IDLE;
        endcase
    end

    // While reset is asserted the CPU keeps the bus even if the FSM is still in XFER.
    always_comb begin
        w_wb_own            = (r_state == S_XFER) & rst_n;
        w_own_cyc           = w_wb_own ? w_wb_req : cpu_cyc;
        w_own_we            = w_wb_own ? wbs_we_i : cpu_we;
        w_dev               = w_wb_own ? wbs_adr_i[7:6] : cpu_addr[7:6];
        bus_cyc             = w_own_cyc;
        bus_addr            = w_wb_own ? wbs_adr_i[5:0] : cpu_addr[5:0];
        bus_data_out        = w_wb_own ? wbs_dat_i : cpu_dat_o;
        bus_we_gpios        = w_own_cyc & w_own_we & (w_dev == 2'd0);
        bus_we_timers       = w_own_cyc & w_own_we & (w_dev == 2'd1);
        bus_we_serial_ports = w_own_cyc & w_own_we & (w_dev == 2'd2);
        bus_we_sid          = w_own_cyc & w_own_we & (w_dev == 2'd3);
        w_mux               = w_dev == 2'd0 ? bus_in_gpios :
                              w_dev == 2'd1 ? bus_in_timers :
                              w_dev == 2'd2 ? bus_in_serial_ports : bus_in_sid;
        cpu_dat_i           = w_wb_own ? 8'h00 : w_mux;
        cpu_hold            = w_wb_own & cpu_cyc;
        wbs_ack_o           = r_state == S_ACK;
        wbs_dat_o           = r_dat;
    end

    always_ff @(posedge wb_clk_i)
        if (!rst_n) begin
            r_wait_cnt <= 8'd0;
            r_dat      <= 8'h00;
        end else begin
            r_wait_cnt <= r_state == S_WAIT ? r_wait_cnt + 8'd1 : 8'd0;
            if (w_wb_own & w_wb_req & !wbs_we_i) r_dat <= w_mux;
            else if (w_stat_rd)                  r_dat <= w_stat_dat;
        end

`ifdef IO_ARB_STATS_EN
    logic [15:0] r_grants, r_forced_holds;
    assign w_stat     = wbs_adr_i[8];
    assign w_stat_dat = wbs_adr_i[1:0] == 2'd0 ? r_grants[7:0] :
                        wbs_adr_i[1:0] == 2'd1 ? r_grants[15:8] :
                        wbs_adr_i[1:0] == 2'd2 ? r_forced_holds[7:0] : r_forced_holds[15:8];
    always_ff @(posedge wb_clk_i)
        if (!rst_n || ((r_state == S_IDLE) & w_wb_req & w_stat & wbs_we_i)) begin
            r_grants       <= 16'd0;
            r_forced_holds <= 16'd0;
        end else begin
            if (r_state == S_XFER && r_grants != 16'hFFFF) r_grants <= r_grants + 16'd1;
            if (w_forced && r_forced_holds != 16'hFFFF)    r_forced_holds <= r_forced_holds + 16'd1;
        end
`else
    logic w_unused_adr8;
    assign w_unused_adr8 = wbs_adr_i[8] | w_forced;
    assign w_stat        = 1'b0;
    assign w_stat_dat    = 8'h00;
`endif
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: randomized self-checking bench for io_bus_arbiter against a latency/data model.
module tb_io_bus_arbiter;
    localparam int MAX_WAIT = 8;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpu_cyc = 1'b0, cpu_we = 1'b0;
    logic [7:0] cpu_addr = 8'h00, cpu_dat_o = 8'h00, cpu_dat_i;
    logic       cpu_hold;
    logic       wb_io_sel = 1'b0, wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [8:0] wbs_adr_i = 9'h000;
    logic [7:0] wbs_dat_i = 8'h00, wbs_dat_o;
    logic       wbs_ack_o, bus_cyc;
    logic [5:0] bus_addr;
    logic [7:0] bus_data_out;
    logic       bus_we_gpios, bus_we_timers, bus_we_serial_ports, bus_we_sid;
    logic [7:0] dev_in [4];
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    io_bus_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .wb_clk_i(clk), .rst_n(rst_n),
        .cpu_cyc(cpu_cyc), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_dat_o(cpu_dat_o),
        .cpu_dat_i(cpu_dat_i), .cpu_hold(cpu_hold),
        .wb_io_sel(wb_io_sel), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
        .bus_cyc(bus_cyc), .bus_addr(bus_addr), .bus_data_out(bus_data_out),
        .bus_we_gpios(bus_we_gpios), .bus_we_timers(bus_we_timers),
        .bus_we_serial_ports(bus_we_serial_ports), .bus_we_sid(bus_we_sid),
        .bus_in_gpios(dev_in[0]), .bus_in_timers(dev_in[1]),
        .bus_in_serial_ports(dev_in[2]), .bus_in_sid(dev_in[3])
    );

    function automatic logic [3:0] we_vec();
        return {bus_we_sid, bus_we_serial_ports, bus_we_timers, bus_we_gpios};
    endfunction

    function automatic int exp_lat(input int busy);
        return (busy < MAX_WAIT ? busy : MAX_WAIT) + 2;
    endfunction

    task automatic next_win();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_devs();
        for (int i = 0; i < 4; i++) dev_in[i] = 8'($urandom_range(1, 255));
    endtask

    // Runs one WB access with cpu_cyc high for the first `busy` windows; reports observations.
    task automatic run_wb(input logic we, input logic [8:0] adr, input logic [7:0] dat, input int busy,
                          output int lat, output int we_cnt, output int hold_cnt, output logic we_ok,
                          output logic [7:0] xfer_cd, output logic ack_after, output logic [7:0] rdat);
        logic [7:0] prev_cd;
        lat = -1; we_cnt = 0; hold_cnt = 0; we_ok = 1'b1; xfer_cd = 8'hEE; prev_cd = 8'hEE;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wb_io_sel = 1'b1;
        wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = dat;
        cpu_we = 1'b0; cpu_addr = 8'($urandom);
        for (int c = 0; c < 40 && lat < 0; c++) begin
            cpu_cyc = c < busy;
            @(negedge clk);
            if (we_vec() != 4'b0) begin
                we_cnt++;
                if (we_vec() != (4'b1 << adr[7:6]) || bus_addr != adr[5:0] || bus_data_out != dat)
                    we_ok = 1'b0;
            end
            hold_cnt += int'(cpu_hold);
            if (wbs_ack_o) begin
                lat = c;
                xfer_cd = prev_cd;
            end
            prev_cd = cpu_dat_i;
            next_win();
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; cpu_cyc = 1'b0;
        @(negedge clk);
        ack_after = wbs_ack_o;
        rdat = wbs_dat_o;
        next_win();
    endtask

    task automatic check_txn(input string nm, input logic we, input logic [8:0] adr, input logic [7:0] dat,
                             input int busy, input logic [7:0] exp_rd);
        int lat, wc, hc;
        logic wok, aa;
        logic [7:0] xcd, rd;
        run_wb(we, adr, dat, busy, lat, wc, hc, wok, xcd, aa, rd);
        checks += 5;
        if (lat !== exp_lat(busy)) begin
            failures++; $display("FAIL %s latency got=%0d exp=%0d", nm, lat, exp_lat(busy));
        end
        if (wc !== int'(we) || !wok) begin
            failures++; $display("FAIL %s bus_we pulses got=%0d ok=%0b exp=%0d", nm, wc, wok, int'(we));
        end
        if (hc !== int'(busy > MAX_WAIT + 1)) begin
            failures++; $display("FAIL %s cpu_hold cycles got=%0d exp=%0d", nm, hc, int'(busy > MAX_WAIT + 1));
        end
        if (xcd !== 8'h00) begin
            failures++; $display("FAIL %s cpu_dat_i during xfer got=%h exp=00", nm, xcd);
        end
        if (aa !== 1'b0) begin
            failures++; $display("FAIL %s ack not single-cycle got=%b exp=0", nm, aa);
        end
        if (!we) begin
            checks++;
            if (rd !== exp_rd) begin
                failures++; $display("FAIL %s wbs_dat_o got=%h exp=%h", nm, rd, exp_rd);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) next_win();
        cpu_cyc = 1'b1; cpu_we = 1'b1; cpu_addr = 8'hC5; cpu_dat_o = 8'h3C;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wb_io_sel = 1'b1; wbs_adr_i = 9'h011;
        @(negedge clk);
        checks += 3;
        if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 8'h00) begin
            failures++; $display("FAIL reset_state ack=%b dat=%h exp ack=0 dat=00", wbs_ack_o, wbs_dat_o);
        end
        if (cpu_hold !== 1'b0) begin
            failures++; $display("FAIL reset_hold got=%b exp=0", cpu_hold);
        end
        if (bus_cyc !== 1'b1 || bus_addr !== 6'h05 || bus_data_out !== 8'h3C || we_vec() !== 4'b1000) begin
            failures++; $display("FAIL reset_cpu_owner cyc=%b addr=%h data=%h we=%b exp 1/05/3c/1000",
                                 bus_cyc, bus_addr, bus_data_out, we_vec());
        end
        next_win();
        cpu_cyc = 1'b0; cpu_we = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        next_win();
        rst_n = 1'b1;
        next_win();
    endtask

    task automatic test_cpu_pass();
        rand_devs();
        for (int i = 0; i < 8; i++) begin
            cpu_cyc = 1'b1;
            cpu_we = i == 0 ? 1'b0 : 1'($urandom);
            cpu_addr = i == 0 ? 8'hC3 : 8'($urandom);
            cpu_dat_o = 8'($urandom);
            if (i == 0) dev_in[3] = 8'h77;
            @(negedge clk);
            checks += 2;
            if (cpu_dat_i !== dev_in[cpu_addr[7:6]] || cpu_hold !== 1'b0) begin
                failures++; $display("FAIL cpu_read addr=%h got=%h hold=%b exp=%h hold=0",
                                     cpu_addr, cpu_dat_i, cpu_hold, dev_in[cpu_addr[7:6]]);
            end
            if (bus_addr !== cpu_addr[5:0] || bus_data_out !== cpu_dat_o ||
                we_vec() !== (cpu_we ? 4'b1 << cpu_addr[7:6] : 4'b0)) begin
                failures++; $display("FAIL cpu_bus addr=%h data=%h we=%b exp addr=%h data=%h",
                                     bus_addr, bus_data_out, we_vec(), cpu_addr[5:0], cpu_dat_o);
            end
            next_win();
        end
        cpu_cyc = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic test_idle_write();
        rand_devs();
        check_txn("idle_write", 1'b1, 9'h041, 8'h5A, 0, 8'h00);
    endtask

    task automatic test_forced_read();
        rand_devs();
        check_txn("forced_read", 1'b0, 9'h002, 8'h00, 100, dev_in[0]);
        check_txn("release_at_slot", 1'b0, 9'h0C1, 8'h00, MAX_WAIT + 1, dev_in[3]);
    endtask

    task automatic test_abort();
        int acks = 0, wes = 0;
        rand_devs();
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wb_io_sel = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 9'h085; wbs_dat_i = 8'hA5;
        cpu_cyc = 1'b1; cpu_we = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (c == 4) wbs_stb_i = 1'b0;
            @(negedge clk);
            acks += int'(wbs_ack_o);
            wes += int'(we_vec() != 4'b0);
            next_win();
        end
        wbs_cyc_i = 1'b0; cpu_cyc = 1'b0;
        checks++;
        if (acks !== 0 || wes !== 0) begin
            failures++; $display("FAIL abort acks=%0d we_cycles=%0d exp 0/0", acks, wes);
        end
        check_txn("after_abort", 1'b0, 9'h042, 8'h00, 0, dev_in[1]);
    endtask

    task automatic test_reset_xfer();
        int acks = 0;
        rand_devs();
        check_txn("pre_reset_read", 1'b0, 9'h040, 8'h00, 0, dev_in[1]);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wb_io_sel = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 9'h080; wbs_dat_i = 8'h96;
        next_win();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (we_vec() !== 4'b0 || cpu_hold !== 1'b0) begin
            failures++; $display("FAIL reset_in_xfer we=%b hold=%b exp 0000/0", we_vec(), cpu_hold);
        end
        next_win();
        rst_n = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        cpu_cyc = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h81;
        @(negedge clk);
        checks += 2;
        if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 8'h00) begin
            failures++; $display("FAIL reset_xfer_state ack=%b dat=%h exp 0/00", wbs_ack_o, wbs_dat_o);
        end
        if (cpu_dat_i !== dev_in[2] || cpu_hold !== 1'b0) begin
            failures++; $display("FAIL cpu_after_reset got=%h hold=%b exp=%h/0", cpu_dat_i, cpu_hold, dev_in[2]);
        end
        next_win();
        cpu_cyc = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            acks += int'(wbs_ack_o);
            next_win();
        end
        checks++;
        if (acks !== 0) begin
            failures++; $display("FAIL late_ack_after_reset got=%0d exp=0", acks);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic we;
            logic [8:0] adr;
            rand_devs();
            we = 1'($urandom);
            adr = {1'b0, 8'($urandom)};
            check_txn("random", we, adr, 8'($urandom), int'($urandom_range(0, MAX_WAIT + 4)), dev_in[adr[7:6]]);
        end
    endtask

`ifdef IO_ARB_STATS_EN
    task automatic stat_access(input logic we, input logic [1:0] idx, input logic [7:0] exp_rd);
        int lat, wc, hc;
        logic wok, aa;
        logic [7:0] xcd, rd;
        run_wb(we, {7'b1000000, idx}, 8'hFF, 3, lat, wc, hc, wok, xcd, aa, rd);
        checks += 2;
        if (lat !== 1 || wc !== 0 || hc !== 0) begin
            failures++; $display("FAIL stat_access lat=%0d we=%0d hold=%0d exp 1/0/0", lat, wc, hc);
        end
        if (!we && rd !== exp_rd) begin
            failures++; $display("FAIL stat_read idx=%0d got=%h exp=%h", idx, rd, exp_rd);
        end
    endtask

    task automatic test_stats();
        int grants = 0, forced = 0;
        stat_access(1'b1, 2'd0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            int busy;
            rand_devs();
            busy = i == 0 ? 100 : int'($urandom_range(0, MAX_WAIT + 3));
            check_txn("stats_txn", 1'b0, 9'h002, 8'h00, busy, dev_in[0]);
            grants++;
            forced += int'(busy > MAX_WAIT);
        end
        stat_access(1'b0, 2'd0, 8'(grants));
        stat_access(1'b0, 2'd1, 8'(grants >> 8));
        stat_access(1'b0, 2'd2, 8'(forced));
        stat_access(1'b0, 2'd3, 8'(forced >> 8));
        stat_access(1'b1, 2'd0, 8'h00);
        stat_access(1'b0, 2'd0, 8'h00);
        stat_access(1'b0, 2'd2, 8'h00);
    endtask
`endif

    initial begin
        for (int i = 0; i < 4; i++) dev_in[i] = 8'h00;
        test_reset();
        test_cpu_pass();
        test_idle_write();
        test_forced_read();
        test_abort();
        test_reset_xfer();
        test_random();
`ifdef IO_ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
